// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL reset/lock sequencer.
// The state enum, output bundle and default timings live here so that the controller and its users agree on them.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } pll_state_e;

    localparam int DEF_RESET_CYCLES        = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_MAX_RETRIES         = 3;

    // Consecutive low synchronized samples that count as lock loss in RUN when filtering is built in.
    localparam int LOCK_FILTER_LEN = 4;

    typedef struct packed {
        logic pll_reset;
        logic sys_rst_n;
        logic locked;
        logic fault;
    } ctrl_out_t;

    // Moore output decode; registered together with the state it belongs to.
    function automatic ctrl_out_t state_outputs(pll_state_e s);
        ctrl_out_t o;
        o.pll_reset = (s == RST_PLL) || (s == FAULT);
        o.sys_rst_n = (s == RUN);
        o.locked    = (s == RUN);
        o.fault     = (s == FAULT);
        return o;
    endfunction

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// Signal bundle between the PLL lock sequencer (master) and the PLL / system side (slave).
interface pll_lock_ctrl_if;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       locked;
    logic       fault;
    logic       lock_lost;
    logic [3:0] retry_cnt;

    modport master (
        input  pll_lock, relock_req,
        output pll_reset, sys_rst_n, locked, fault, lock_lost, retry_cnt
    );

    modport slave (
        output pll_lock, relock_req,
        input  pll_reset, sys_rst_n, locked, fault, lock_lost, retry_cnt
    );
endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            q_reg    <= 1'b0;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses PLL RESET, waits for stable lock, releases sys_rst_n, re-arms on loss/timeout.
// Optional build macro PLL_LOCK_FILTER_EN: in RUN, lock loss needs LOCK_FILTER_LEN consecutive low samples.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES        = DEF_RESET_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic            clkin,
    input  logic            rst_n,
    pll_lock_ctrl_if.master ctl
);
    localparam int CNT_MAX = max3(RESET_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    logic             lock_s;
    logic             lock_loss;
    pll_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    ctrl_out_t        outs_reg;
    logic             lock_lost_reg;
    logic [3:0]       retry_reg;

    sync_2ff u_lock_sync (
        .clk  (clkin),
        .rst_n(rst_n),
        .d    (ctl.pll_lock),
        .q    (lock_s)
    );

`ifdef PLL_LOCK_FILTER_EN
    localparam int             LOW_W    = $clog2(LOCK_FILTER_LEN);
    localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(LOCK_FILTER_LEN - 1);

    logic [LOW_W-1:0] low_cnt_reg;

    // Counts earlier consecutive low samples in RUN; the current low sample completes the run.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt_reg <= '0;
        end else if (state_reg != RUN || lock_s) begin
            low_cnt_reg <= '0;
        end else if (low_cnt_reg != LOW_LAST) begin
            low_cnt_reg <= low_cnt_reg + LOW_W'(1);
        end
    end

    assign lock_loss = !lock_s && (low_cnt_reg == LOW_LAST);
`else
    assign lock_loss = !lock_s;
`endif

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RST_PLL;
            cnt_reg       <= '0;
            outs_reg      <= state_outputs(RST_PLL);
            lock_lost_reg <= 1'b0;
            retry_reg     <= 4'd0;
        end else begin
            // Every transition below overrides this with a cleared counter.
            cnt_reg <= cnt_reg + CNT_W'(1);
            case (state_reg)
                RST_PLL: begin
                    if (cnt_reg == RESET_LAST) begin
                        state_reg <= WAIT_LOCK;
                        outs_reg  <= state_outputs(WAIT_LOCK);
                        cnt_reg   <= '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_reg <= STABLE;
                        outs_reg  <= state_outputs(STABLE);
                        cnt_reg   <= '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        cnt_reg <= '0;
                        if (retry_reg == RETRY_MAX) begin
                            state_reg <= FAULT;
                            outs_reg  <= state_outputs(FAULT);
                        end else begin
                            retry_reg <= retry_reg + 4'd1;
                            state_reg <= RST_PLL;
                            outs_reg  <= state_outputs(RST_PLL);
                        end
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_reg <= WAIT_LOCK;
                        outs_reg  <= state_outputs(WAIT_LOCK);
                        cnt_reg   <= '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_reg <= RUN;
                        outs_reg  <= state_outputs(RUN);
                        retry_reg <= 4'd0;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    // Lock loss wins over a simultaneous relock request and keeps lock_lost set.
                    if (lock_loss) begin
                        lock_lost_reg <= 1'b1;
                        state_reg     <= RST_PLL;
                        outs_reg      <= state_outputs(RST_PLL);
                        cnt_reg       <= '0;
                    end else if (ctl.relock_req) begin
                        lock_lost_reg <= 1'b0;
                        state_reg     <= RST_PLL;
                        outs_reg      <= state_outputs(RST_PLL);
                        cnt_reg       <= '0;
                    end
                end
                FAULT: begin
                    if (ctl.relock_req) begin
                        lock_lost_reg <= 1'b0;
                        retry_reg     <= 4'd0;
                        state_reg     <= RST_PLL;
                        outs_reg      <= state_outputs(RST_PLL);
                        cnt_reg       <= '0;
                    end
                end
                default: begin
                    state_reg <= RST_PLL;
                    outs_reg  <= state_outputs(RST_PLL);
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign ctl.pll_reset = outs_reg.pll_reset;
    assign ctl.sys_rst_n = outs_reg.sys_rst_n;
    assign ctl.locked    = outs_reg.locked;
    assign ctl.fault     = outs_reg.fault;
    assign ctl.lock_lost = lock_lost_reg;
    assign ctl.retry_cnt = retry_reg;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Self-checking bench for pll_lock_ctrl: directed sequences plus random lock waveforms against a timing model.
module tb_pll_lock_ctrl;
    localparam int RC = 4;
    localparam int SC = 8;
    localparam int TC = 32;
    localparam int MR = 2;
`ifdef PLL_LOCK_FILTER_EN
    localparam int FILT = 4;
`else
    localparam int FILT = 1;
`endif
    localparam logic [8:0] RESET_OUTS = 9'h100;

    localparam int M_RST   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_STAB  = 2;
    localparam int M_RUN   = 3;
    localparam int M_FAULT = 4;

    logic clkin = 1'b0;
    logic rst_n = 1'b0;
    always #5 clkin = ~clkin;

    pll_lock_ctrl_if bus ();

    pll_lock_ctrl #(
        .RESET_CYCLES       (RC),
        .LOCK_STABLE_CYCLES (SC),
        .LOCK_TIMEOUT_CYCLES(TC),
        .MAX_RETRIES        (MR)
    ) dut (
        .clkin(clkin),
        .rst_n(rst_n),
        .ctl  (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Timing model: phase plus cycles spent in it; lock is seen two edges after it is driven.
    int m_mode, m_age, m_lows, m_retry;
    bit m_lost;
    bit lock_hist[$];

    function automatic void model_reset();
        m_mode = M_RST; m_age = 0; m_lows = 0; m_retry = 0; m_lost = 0;
        lock_hist = '{0, 0};
    endfunction

    function automatic void enter(input int mode);
        m_mode = mode; m_age = 0; m_lows = 0;
    endfunction

    function automatic void model_edge(input bit lock_in, input bit relock);
        bit ls;
        ls = lock_hist.pop_front();
        lock_hist.push_back(lock_in);
        case (m_mode)
            M_RST: begin
                m_age++;
                if (m_age == RC) enter(M_WAIT);
            end
            M_WAIT: begin
                if (ls) enter(M_STAB);
                else begin
                    m_age++;
                    if (m_age == TC) begin
                        if (m_retry == MR) enter(M_FAULT);
                        else begin m_retry++; enter(M_RST); end
                    end
                end
            end
            M_STAB: begin
                if (!ls) enter(M_WAIT);
                else begin
                    m_age++;
                    if (m_age == SC) begin m_retry = 0; enter(M_RUN); end
                end
            end
            M_RUN: begin
                m_lows = ls ? 0 : m_lows + 1;
                if (m_lows >= FILT) begin m_lost = 1; enter(M_RST); end
                else if (relock) begin m_lost = 0; enter(M_RST); end
            end
            default: begin
                if (relock) begin m_retry = 0; m_lost = 0; enter(M_RST); end
            end
        endcase
    endfunction

    function automatic logic [8:0] m_outs();
        logic [3:0] r;
        r = 4'(m_retry);
        return {(m_mode == M_RST) || (m_mode == M_FAULT), m_mode == M_RUN, m_mode == M_RUN,
                m_mode == M_FAULT, m_lost, r};
    endfunction

    function automatic logic [8:0] dut_outs();
        return {bus.pll_reset, bus.sys_rst_n, bus.locked, bus.fault, bus.lock_lost, bus.retry_cnt};
    endfunction

    task automatic step();
        @(posedge clkin);
        if (!rst_n) model_reset();
        else model_edge(bus.pll_lock, bus.relock_req);
        #1;
        check("cycle", dut_outs(), m_outs());
    endtask

    task automatic pulse_relock();
        bus.relock_req = 1'b1;
        step();
        bus.relock_req = 1'b0;
    endtask

    task automatic abort_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check(tag, dut_outs(), RESET_OUTS);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n, rises, seq, bad;
        bit prev;
        logic [3:0] last_r;

        bus.pll_lock   = 1'b0;
        bus.relock_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clkin);
        #1;
        check("reset_state", dut_outs(), RESET_OUTS);
        rst_n = 1'b1;

        // Normal lock
        n = 0;
        while (bus.pll_reset && n < 50) begin step(); n++; end
        check("rst_pulse_width", n, RC);
        repeat (9) step();
        bus.pll_lock = 1'b1;
        n = 0;
        while (!bus.sys_rst_n && n < 100) begin step(); n++; end
        check("lock_to_release", n, SC + 3);
        check("locked_in_run", bus.locked, 1);
        $display("[tb] normal lock: release after %0d cycles", n);

        // Lock loss in RUN for 20 cycles
        bus.pll_lock = 1'b0;
        n = 0;
        while (bus.sys_rst_n && n < 50) begin step(); n++; end
        check("loss_latency", n, FILT + 2);
        check("loss_pll_reset", bus.pll_reset, 1);
        check("lock_lost_set", bus.lock_lost, 1);
        while (n < 20) begin step(); n++; end
        bus.pll_lock = 1'b1;
        n = 0;
        while (!bus.locked && n < 200) begin step(); n++; end
        check("relock_after_loss", bus.locked, 1);
        $display("[tb] lock loss: relocked, lock_lost=%0b", bus.lock_lost);

        // relock_req in RUN restarts and clears the sticky flag
        pulse_relock();
        check("relock_clears_lost", bus.lock_lost, 0);
        check("relock_pll_reset", bus.pll_reset, 1);

        // Bounce in STABLE
        n = 0;
        while (!(m_mode == M_STAB && m_age == 4) && n < 50) begin step(); n++; end
        check("reach_stable", m_mode == M_STAB, 1);
        bus.pll_lock = 1'b0;
        step();
        bus.pll_lock = 1'b1;
        n = 0;
        while (!bus.sys_rst_n && n < 100) begin step(); n++; end
        check("bounce_release", n, SC + 3);
        $display("[tb] bounce: release %0d cycles after lock returned", n);

        // Timeout to fault
        bus.pll_lock = 1'b0;
        rises = 0; seq = 0; last_r = bus.retry_cnt;
        prev = bus.pll_reset;
        n = 0;
        while (!bus.fault && n < 500) begin
            step(); n++;
            if (!prev && bus.pll_reset && !bus.fault) rises++;
            if (bus.retry_cnt != last_r) begin
                seq = seq * 16 + int'(bus.retry_cnt);
                last_r = bus.retry_cnt;
            end
            prev = bus.pll_reset;
        end
        check("fault_reached", bus.fault, 1);
        check("timeout_pulses", rises, MR + 1);
        check("retry_sequence", seq, 32'h12);
        check("fault_pll_reset", bus.pll_reset, 1);
        repeat (10) step();
        $display("[tb] timeout: fault after %0d cycles, %0d pulses", n, rises);

        // Recovery from fault
        bus.pll_lock = 1'b1;
        pulse_relock();
        check("recover_fault_clr", bus.fault, 0);
        check("recover_retry_clr", bus.retry_cnt, 0);
        n = 0;
        while (!bus.locked && n < 200) begin step(); n++; end
        check("recover_locked", bus.locked, 1);
        $display("[tb] recovery: locked after %0d cycles", n);

`ifdef PLL_LOCK_FILTER_EN
        bus.pll_lock = 1'b0;
        step();
        step();
        bus.pll_lock = 1'b1;
        bad = 0;
        repeat (10) begin
            step();
            if (!bus.locked || !bus.sys_rst_n || bus.pll_reset) bad++;
        end
        check("glitch_ignored", bad, 0);
        $display("[tb] glitch: %0d disturbed cycles", bad);
`endif

        // Abort during WAIT_LOCK
        bus.pll_lock = 1'b0;
        pulse_relock();
        n = 0;
        while (!(m_mode == M_WAIT && m_age >= 3) && n < 50) begin step(); n++; end
        check("reach_wait", m_mode == M_WAIT, 1);
        abort_reset("abort_outputs");
        $display("[tb] abort in WAIT_LOCK");

        // Random lock waveforms, relock requests and aborts
        for (int seg = 0; seg < 40; seg++) begin
            int kind, len;
            kind = int'($urandom_range(0, 11));
            if (kind == 0) begin
                abort_reset("rand_abort");
                $display("[tb] seg %0d: abort", seg);
            end else begin
                bus.pll_lock = ($urandom_range(0, 3) != 0);
                len = (kind < 4) ? int'($urandom_range(1, 5)) : int'($urandom_range(1, 60));
                for (int c = 0; c < len; c++) begin
                    bus.relock_req = ($urandom_range(0, 24) == 0);
                    step();
                end
                bus.relock_req = 1'b0;
                $display("[tb] seg %0d: lock=%0b len=%0d mode=%0d", seg, bus.pll_lock, len, m_mode);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Reset/lock sequencer for the Gowin rPLL wrappers. It drives the PLL `RESET` input (currently tied low in the wrappers) and monitors the PLL `LOCK` output (currently left unconnected). It releases a downstream reset only after lock has been stable for a set time, and re-arms the PLL on lock loss or lock timeout. It sits in the clock-generation area, clocked by the PLL's own input reference clock (for example 50 MHz).

## Interface
Parameters:
- `RESET_CYCLES`, 16: PLL reset pulse width, in clkin cycles (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-high lock samples required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: maximum wait for lock after reset deassertion (≥2).
- `MAX_RETRIES`, 3: timeout-driven PLL resets allowed before entering FAULT (0..15).

Ports:
- `clkin` input 1: reference clock; the single clock of the block.
- `rst_n` input 1: asynchronous, active-low reset.
- `pll_lock` input 1: PLL `LOCK`; asynchronous to clkin.
- `relock_req` input 1: single-cycle request to restart the sequence; honoured in RUN and FAULT only.
- `pll_reset` output 1: to PLL `RESET`, active-high.
- `sys_rst_n` output 1: downstream reset, active-low, in the clkin domain. Consumers in the clkout domain add their own synchronizer.
- `locked` output 1: high in RUN.
- `fault` output 1: high in FAULT.
- `lock_lost` output 1: sticky; set on lock loss in RUN, cleared by `relock_req` or `rst_n`.
- `retry_cnt` output 4: count of timeout retries since the last successful release.

## Operation
- `pll_lock` passes through a 2-FF synchronizer to give `lock_s`. All decisions use `lock_s` only.
- One counter is shared by all states and cleared on every state transition.
- States and transitions:
  - **RST_PLL:** `pll_reset`=1. After `RESET_CYCLES` cycles, go to WAIT_LOCK.
  - **WAIT_LOCK:** `pll_reset`=0.
    - If `lock_s`=1, go to STABLE.
    - Else, if the counter equals `LOCK_TIMEOUT_CYCLES-1`:
      - if `retry_cnt`==`MAX_RETRIES`, go to FAULT;
      - otherwise increment `retry_cnt` and go to RST_PLL.
  - **STABLE:**
    - If `lock_s`=0, return to WAIT_LOCK with the timeout count restarted.
    - After `LOCK_STABLE_CYCLES` consecutive high samples, go to RUN and clear `retry_cnt`.
  - **RUN:** `sys_rst_n`=1, `locked`=1.
    - On lock loss, set `lock_lost` and go to RST_PLL.
    - On `relock_req`, go to RST_PLL.
  - **FAULT:** `pll_reset`=1, `fault`=1. Only `relock_req` or `rst_n` leaves this state. `relock_req` clears `retry_cnt`, `fault` and `lock_lost`, then goes to RST_PLL.
- `sys_rst_n`=0 in every state except RUN.
- If lock loss and `relock_req` occur in the same RUN cycle, lock loss takes priority: go to RST_PLL and set `lock_lost`. The `relock_req` clear does not apply in that cycle.
- `relock_req` in RST_PLL, WAIT_LOCK or STABLE is ignored.
- `retry_cnt` saturates at `MAX_RETRIES`.

## Timing
- All outputs are registered.
- Values while `rst_n`=0:
  - `pll_reset`=1, `sys_rst_n`=0;
  - `locked`=0, `fault`=0, `lock_lost`=0, `retry_cnt`=0;
  - state RST_PLL, counter 0.
- `rst_n` mid-sequence aborts immediately to these values. On `rst_n` rising, the full RST_PLL pulse restarts.
- Synchronizer latency is 2 cycles. A state change appears on the outputs after the following edge.
- `pll_reset` stays high for exactly `RESET_CYCLES` cycles per entry into RST_PLL.
- `sys_rst_n` rises `LOCK_STABLE_CYCLES+3` cycles after `pll_lock` rises, with `pll_lock` held high throughout.
- Lock loss in RUN: `sys_rst_n` and `locked` fall 3 cycles after `pll_lock` falls, and `pll_reset` rises on the same edge.

## Configuration
- `PLL_LOCK_FILTER_EN` defined: lock loss in RUN requires 4 consecutive low `lock_s` samples. `sys_rst_n` then falls 6 cycles after a sustained `pll_lock` fall. Low glitches of 3 or fewer synchronized cycles are ignored.
- `PLL_LOCK_FILTER_EN` undefined: a single low `lock_s` sample is treated as lock loss.
- STABLE always treats a single low sample as failure, independent of the macro.

## Structure
- Package `pll_ctrl_pkg`: state enum (RST_PLL, WAIT_LOCK, STABLE, RUN, FAULT), default parameter constants, and filter depth constant `LOCK_FILTER_LEN`=4.
- Counter width is derived from the largest of the three cycle parameters.
- Sub-module `sync_2ff`: a 1-bit, two-flop synchronizer with reset value 0.

## Test plan
Bench parameters: `RESET_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `MAX_RETRIES`=2.
- **Normal lock:** release `rst_n`; `pll_lock` rises 10 cycles after `pll_reset` falls. Required: `pll_reset` high for exactly 4 cycles; `sys_rst_n`=1 and `locked`=1 exactly 11 cycles after the `pll_lock` rise.
- **Lock bounce:** in STABLE, drop `pll_lock` for 1 cycle at sample 5. Required: return to WAIT_LOCK; `sys_rst_n` stays 0 until 8 fresh consecutive high samples.
- **Timeout to fault:** `pll_lock` held 0. Required: 3 `pll_reset` pulses, `retry_cnt` reads 1 and then 2, then `fault`=1 with `pll_reset` held 1.
- **Recovery from fault:** from FAULT, pulse `relock_req` with `pll_lock`=1. Required: `fault`=0 and `retry_cnt`=0; `locked`=1 after the standard sequence.
- **Lock loss in RUN:** drop `pll_lock` for 20 cycles. Required: `sys_rst_n` falls 3 cycles later (6 cycles with `PLL_LOCK_FILTER_EN`), `lock_lost`=1, and a new `pll_reset` pulse follows.
- **Glitch and abort (filter built in):** with `PLL_LOCK_FILTER_EN`, a 2-cycle `pll_lock` low glitch in RUN produces no output change. Assert `rst_n`=0 during WAIT_LOCK: all outputs take their reset values immediately.
